// File: rtl/led_keys_ctrl_pkg.sv
// rtl/led_keys_ctrl_pkg.sv - shared types and constants for the LED key control stage
package led_keys_ctrl_pkg;

  typedef enum logic [1:0] {
    KEY_RELEASED     = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_PRESSED      = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int SPEED_W   = 2;
  localparam int KEY_DIR   = 0;
  localparam int KEY_SPEED = 1;

endpackage

// File: rtl/led_keys_ctrl_key_debounce.sv
// rtl/led_keys_ctrl_key_debounce.sv - 2-flop synchronizer plus press/release debounce FSM for one key
module key_debounce
  import led_keys_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic evt,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  key_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          evt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      state <= KEY_RELEASED;
      cnt   <= '0;
      evt   <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      state <= state_nx;
      cnt   <= cnt_nx;
      evt   <= evt_nx;
    end
  end

  // sync2 is still active-low here: 0 means the key is held down
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    evt_nx   = 1'b0;
    case (state)
      KEY_RELEASED: begin
        if (!sync2) begin
          state_nx = KEY_PRESS_WAIT;
          cnt_nx   = CW'(1);
        end else begin
          cnt_nx = '0;
        end
      end
      KEY_PRESS_WAIT: begin
        if (sync2) begin
          state_nx = KEY_RELEASED;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = KEY_PRESSED;
          cnt_nx   = '0;
          evt_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      KEY_PRESSED: begin
        if (sync2) begin
          state_nx = KEY_RELEASE_WAIT;
          cnt_nx   = CW'(1);
        end
      end
      KEY_RELEASE_WAIT: begin
        if (!sync2) begin
          state_nx = KEY_PRESSED;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = KEY_RELEASED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = KEY_RELEASED;
        cnt_nx   = '0;
      end
    endcase
  end

  assign level = (state == KEY_PRESSED) || (state == KEY_RELEASE_WAIT);

endmodule

// File: rtl/led_keys_ctrl.sv
// rtl/led_keys_ctrl.sv - debounced direction/speed keys and selectable-rate step strobe for the LED rotator
module led_keys_ctrl
  import led_keys_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_BASE_LOG2  = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         key_n,
  output logic               direction,
  output logic [SPEED_W-1:0] speed,
  output logic               step,
  output logic [1:0]         key_evt
);

  logic [1:0]                key_level;
  logic [TICK_BASE_LOG2-1:0] tick_cnt;
  logic [TICK_BASE_LOG2-1:0] tick_last;
  logic                      dir_upd, speed_upd;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dir (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n[KEY_DIR]),
    .evt   (key_evt[KEY_DIR]),
    .level (key_level[KEY_DIR])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_speed (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n[KEY_SPEED]),
    .evt   (key_evt[KEY_SPEED]),
    .level (key_level[KEY_SPEED])
  );

  assign dir_upd   = key_evt[KEY_DIR] && key_level[KEY_DIR];
  assign speed_upd = key_evt[KEY_SPEED] && key_level[KEY_SPEED];

  // 2^(TICK_BASE_LOG2 - speed) - 1 is the all-ones value shifted right by speed
  assign tick_last = {TICK_BASE_LOG2{1'b1}} >> speed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      direction <= 1'b0;
      speed     <= '0;
      step      <= 1'b0;
      tick_cnt  <= '0;
    end else begin
      if (dir_upd) direction <= ~direction;
      if (speed_upd) speed <= speed + SPEED_W'(1);
      // a rate change restarts the period and suppresses any coincident step
      if (speed_upd) begin
        tick_cnt <= '0;
        step     <= 1'b0;
      end else if (tick_cnt == tick_last) begin
        tick_cnt <= '0;
        step     <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + TICK_BASE_LOG2'(1);
        step     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_keys_ctrl.sv
// tb/tb_led_keys_ctrl.sv - directed self-checking bench for led_keys_ctrl
module tb_led_keys_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_n;
  logic       direction;
  logic [1:0] speed;
  logic       step;
  logic [1:0] key_evt;

  int checks = 0;
  int errors = 0;
  logic       exp_dir = 1'b0;
  logic [1:0] exp_speed = 2'd0;

  led_keys_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_BASE_LOG2(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .direction (direction),
    .speed     (speed),
    .step      (step),
    .key_evt   (key_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // press keys in mask cleanly; event expected 6 cycles later, register update one cycle after
  task automatic press(input logic [1:0] mask);
    key_n = key_n & ~mask;
    for (int t = 1; t <= 6; t++) begin
      tick();
      chk("press_evt", {6'd0, key_evt}, (t == 6) ? {6'd0, mask} : 8'd0);
    end
    if (mask[0]) exp_dir = ~exp_dir;
    if (mask[1]) exp_speed = exp_speed + 2'd1;
    tick();
    chk("press_evt_clear", {6'd0, key_evt}, 8'd0);
    chk("press_dir", {7'd0, direction}, {7'd0, exp_dir});
    chk("press_speed", {6'd0, speed}, {6'd0, exp_speed});
    if (mask[1]) chk("upd_no_step", {7'd0, step}, 8'd0);
  endtask

  task automatic release_keys(input logic [1:0] mask);
    key_n = key_n | mask;
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk("release_no_evt", {6'd0, key_evt}, 8'd0);
    end
  endtask

  task automatic measure_period(input int p);
    for (int t = 1; t <= p; t++) begin
      tick();
      chk("period_step", {7'd0, step}, (t == p) ? 8'd1 : 8'd0);
    end
  endtask

  initial begin
    rst   = 1'b0;
    key_n = 2'b11;
    repeat (3) tick();
    chk("rst_dir", {7'd0, direction}, 8'd0);
    chk("rst_speed", {6'd0, speed}, 8'd0);
    chk("rst_step", {7'd0, step}, 8'd0);
    chk("rst_evt", {6'd0, key_evt}, 8'd0);

    // cycle 0 begins here; key0 goes low during cycle 10
    rst = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      chk("base_step", {7'd0, step}, (c % 16 == 0) ? 8'd1 : 8'd0);
      chk("first_evt", {6'd0, key_evt}, (c == 16) ? 8'd1 : 8'd0);
      chk("first_dir", {7'd0, direction}, (c >= 17) ? 8'd1 : 8'd0);
      if (c == 10) key_n[0] = 1'b0;
    end
    exp_dir = 1'b1;

    release_keys(2'b01);
    press(2'b01);
    release_keys(2'b01);

    // bounce: low 2, high 1, low 1, then high
    key_n[0] = 1'b0; tick(); tick();
    key_n[0] = 1'b1; tick();
    key_n[0] = 1'b0; tick();
    key_n[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk("bounce_evt", {6'd0, key_evt}, 8'd0);
      chk("bounce_dir", {7'd0, direction}, {7'd0, exp_dir});
    end
    press(2'b01);
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk("hold_no_repeat", {6'd0, key_evt}, 8'd0);
    end
    release_keys(2'b01);

    press(2'b10); measure_period(8);  measure_period(8);  release_keys(2'b10);
    press(2'b10); measure_period(4);  measure_period(4);  release_keys(2'b10);
    press(2'b10); measure_period(2);  measure_period(2);  release_keys(2'b10);
    press(2'b10); measure_period(16); measure_period(16); release_keys(2'b10);

    press(2'b11);
    release_keys(2'b11);

    // reset with key0 in PRESS_WAIT, counter at 2
    key_n[0] = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("midrst_dir", {7'd0, direction}, 8'd0);
    chk("midrst_speed", {6'd0, speed}, 8'd0);
    chk("midrst_step", {7'd0, step}, 8'd0);
    chk("midrst_evt", {6'd0, key_evt}, 8'd0);
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk("inrst_evt", {6'd0, key_evt}, 8'd0);
    end
    exp_dir = 1'b0;
    exp_speed = 2'd0;
    rst = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      chk("postrst_evt", {6'd0, key_evt}, (t == 6) ? 8'd1 : 8'd0);
    end
    tick();
    chk("postrst_dir", {7'd0, direction}, 8'd1);
    chk("postrst_evt_clear", {6'd0, key_evt}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
